// File: rtl/ps2_key_event_if.sv
// Event handshake between the PS/2 key-event decoder and its consumer.
//   o_evt_valid : head event presented (FIFO not empty)
//   o_evt_code  : base scan code of the head event, prefixes stripped
//   o_evt_ext   : head event carried the E0 prefix
//   o_evt_make  : 1 = press, 0 = release
//   i_evt_ready : consumer takes the head event this cycle
// master = decoder side, slave = consumer side.
interface ps2_key_event_if;
  logic       o_evt_valid;
  logic [7:0] o_evt_code;
  logic       o_evt_ext;
  logic       o_evt_make;
  logic       i_evt_ready;

  modport master (
    output o_evt_valid,
    output o_evt_code,
    output o_evt_ext,
    output o_evt_make,
    input  i_evt_ready
  );

  modport slave (
    input  o_evt_valid,
    input  o_evt_code,
    input  o_evt_ext,
    input  o_evt_make,
    output i_evt_ready
  );
endinterface

// File: rtl/ps2_key_event.sv
// PS/2 scan-code set 2 key-event decoder.
// Folds E0/F0 prefixes into {code, ext, make} events, keeps a held-key bitmap
// for eight game keys, suppresses typematic repeats of held mapped keys and
// queues events in a small FIFO.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_byte[7:0]      : raw scan-code byte, qualified by i_byte_valid strobe
//   evt (master)     : event handshake (valid/code/ext/make, ready)
//   o_keys[7:0]      : held bitmap {P, esc, enter, space, right, left, down, up}
//   o_count[4:0]     : FIFO occupancy
//   o_overflow       : sticky dropped-event flag, cleared by i_clr_ovf pulse
//
// state   | meaning
// --------+------------------------------------------
// IDLE    | no prefix pending
// E0      | extended prefix seen
// F0      | break prefix seen
// E0F0    | extended break prefix seen
module ps2_key_event #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_valid,
  ps2_key_event_if.master       evt,
  output logic [7:0]            o_keys,
  output logic [4:0]            o_count,
  output logic                  o_overflow,
  input  logic                  i_clr_ovf
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  // Loaded on every byte; the prefix is abandoned on the idle cycle that
  // finds the counter at zero, i.e. the TIMEOUT_CYC-th idle cycle.
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [4:0]       DEPTH_C  = 5'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_E0   = 2'd1;
  localparam logic [1:0] ST_F0   = 2'd2;
  localparam logic [1:0] ST_E0F0 = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       keys_q, keys_d;
  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [9:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [4:0]       count_q, count_d;
  logic             ovf_q, ovf_d;

  logic       dec_done;
  logic       dec_ext;
  logic       dec_make;
  logic       key_hit;
  logic [2:0] key_idx;
  logic       repeat_make;
  logic       push;
  logic       pop;
  logic       full;
  logic       accept;
  logic       drop;
  logic [9:0] head;

  // Prefix FSM and idle timeout
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    dec_done = 1'b0;
    dec_ext  = 1'b0;
    dec_make = 1'b0;
    if (i_byte_valid) begin
      tmo_d = TMO_LOAD;
      case (i_byte)
        8'hE0: state_d = ST_E0;
        8'hF0: begin
          if (state_q == ST_IDLE)     state_d = ST_F0;
          else if (state_q == ST_E0)  state_d = ST_E0F0;
        end
        8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF: state_d = ST_IDLE;
        default: begin
          dec_done = 1'b1;
          dec_ext  = (state_q == ST_E0) || (state_q == ST_E0F0);
          dec_make = (state_q == ST_IDLE) || (state_q == ST_E0);
          state_d  = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == '0) state_d = ST_IDLE;
      else             tmo_d   = tmo_q - TMO_W'(1);
    end
  end

  // Held-key map; ext has to match the mapping exactly
  always_comb begin
    key_hit = 1'b1;
    key_idx = 3'd0;
    case ({dec_ext, i_byte})
      9'h175:  key_idx = 3'd0;
      9'h172:  key_idx = 3'd1;
      9'h16B:  key_idx = 3'd2;
      9'h174:  key_idx = 3'd3;
      9'h029:  key_idx = 3'd4;
      9'h05A:  key_idx = 3'd5;
      9'h076:  key_idx = 3'd6;
      9'h04D:  key_idx = 3'd7;
      default: key_hit = 1'b0;
    endcase
  end

  always_comb begin
    repeat_make = dec_done && key_hit && dec_make && keys_q[key_idx];
    keys_d = keys_q;
    if (dec_done && key_hit) keys_d[key_idx] = dec_make;
  end

  // FIFO; a pop frees the slot for a same-cycle push even when full
  always_comb begin
    push   = dec_done && !repeat_make;
    pop    = (count_q != 5'd0) && evt.i_evt_ready;
    full   = (count_q == DEPTH_C);
    accept = push && (!full || pop);
    drop   = push && full && !pop;

    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (accept) begin
      mem_d[wr_q] = {dec_ext, dec_make, i_byte};
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop) rd_d = rd_q + PTR_W'(1);

    case ({accept, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    // a new drop beats a same-cycle clear
    ovf_d = (ovf_q && !i_clr_ovf) || drop;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
      keys_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      keys_q  <= keys_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      mem_q   <= mem_d;
    end
  end

  // Head fields read as zero while empty so stale entries never show
  assign head            = mem_q[rd_q];
  assign evt.o_evt_valid = (count_q != 5'd0);
  assign evt.o_evt_code  = evt.o_evt_valid ? head[7:0] : 8'h00;
  assign evt.o_evt_make  = evt.o_evt_valid ? head[8]   : 1'b0;
  assign evt.o_evt_ext   = evt.o_evt_valid ? head[9]   : 1'b0;
  assign o_keys          = keys_q;
  assign o_count         = count_q;
  assign o_overflow      = ovf_q;

endmodule

// File: tb/tb_ps2_key_event.sv
module tb_ps2_key_event;
  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [7:0] i_byte = 8'h00;
  logic       i_byte_valid = 1'b0;
  logic       i_clr_ovf = 1'b0;
  logic [7:0] o_keys;
  logic [4:0] o_count;
  logic       o_overflow;

  ps2_key_event_if evt_if ();

  ps2_key_event #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .evt          (evt_if),
    .o_keys       (o_keys),
    .o_count      (o_count),
    .o_overflow   (o_overflow),
    .i_clr_ovf    (i_clr_ovf)
  );

  initial forever #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: prefix flags, idle cycle count, event queue {ext,make,code}
  bit         m_e0, m_f0;
  int         m_idle;
  logic [9:0] m_q[$];
  logic [7:0] m_keys;
  bit         m_ovf;

  function automatic int key_of(input logic [7:0] c, input bit ext);
    if (ext  && c == 8'h75) return 0;
    if (ext  && c == 8'h72) return 1;
    if (ext  && c == 8'h6B) return 2;
    if (ext  && c == 8'h74) return 3;
    if (!ext && c == 8'h29) return 4;
    if (!ext && c == 8'h5A) return 5;
    if (!ext && c == 8'h76) return 6;
    if (!ext && c == 8'h4D) return 7;
    return -1;
  endfunction

  function automatic bit is_ignored(input logic [7:0] c);
    return c == 8'h00 || c == 8'hAA || c == 8'hE1 || c == 8'hFA || c == 8'hFE || c == 8'hFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_edge(input logic [7:0] b, input logic v, input logic rdy,
                            input logic clr, input logic rst);
    bit drop;
    bit ext, mk;
    int k;
    drop = 0;
    if (rst) begin
      m_e0 = 0; m_f0 = 0; m_idle = 0; m_q.delete(); m_keys = 8'h00; m_ovf = 0;
      return;
    end
    if (rdy && m_q.size() > 0) void'(m_q.pop_front());
    if (v) begin
      m_idle = 0;
      if (b == 8'hE0) begin
        m_e0 = 1; m_f0 = 0;
      end else if (b == 8'hF0) begin
        m_f0 = 1;
      end else if (is_ignored(b)) begin
        m_e0 = 0; m_f0 = 0;
      end else begin
        ext = m_e0; mk = !m_f0;
        m_e0 = 0; m_f0 = 0;
        k = key_of(b, ext);
        if (!(k >= 0 && mk && m_keys[k])) begin
          if (m_q.size() < DEPTH) m_q.push_back({ext, mk, b});
          else drop = 1;
        end
        if (k >= 0) m_keys[k] = mk;
      end
    end else if (m_e0 || m_f0) begin
      m_idle++;
      if (m_idle >= TMO) begin
        m_e0 = 0; m_f0 = 0; m_idle = 0;
      end
    end
    m_ovf = (m_ovf && !clr) || drop;
  endtask

  task automatic check_all();
    logic [9:0] h;
    h = (m_q.size() > 0) ? m_q[0] : 10'h000;
    chk("evt_valid", 32'(evt_if.o_evt_valid), 32'(m_q.size() > 0));
    chk("evt_code",  32'(evt_if.o_evt_code),  32'(h[7:0]));
    chk("evt_make",  32'(evt_if.o_evt_make),  32'(h[8]));
    chk("evt_ext",   32'(evt_if.o_evt_ext),   32'(h[9]));
    chk("count",     32'(o_count),            32'(m_q.size()));
    chk("keys",      32'(o_keys),             32'(m_keys));
    chk("overflow",  32'(o_overflow),         32'(m_ovf));
  endtask

  task automatic step(input logic [7:0] b, input logic v, input logic rdy,
                      input logic clr, input logic rst = 1'b0);
    i_byte = b; i_byte_valid = v; evt_if.i_evt_ready = rdy; i_clr_ovf = clr; i_rst = rst;
    @(posedge i_clk);
    model_edge(b, v, rdy, clr, rst);
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] b, input logic rdy = 1'b0);
    step(b, 1'b1, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy = 1'b0);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0, rdy, 1'b0);
  endtask

  logic [7:0] pool [16];

  initial begin
    evt_if.i_evt_ready = 1'b0;
    pool = '{8'hE0, 8'hF0, 8'hF0, 8'hE0, 8'h75, 8'h72, 8'h6B, 8'h74,
             8'h29, 8'h5A, 8'h76, 8'h4D, 8'h1C, 8'hAA, 8'hFE, 8'h00};

    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_count", 32'(o_count), 32'd0);
    chk("reset_keys",  32'(o_keys),  32'd0);

    // extended up: press then release
    send(8'hE0); send(8'h75);
    chk("up_make_keys", 32'(o_keys), 32'h01);
    chk("up_make_head", 32'({evt_if.o_evt_ext, evt_if.o_evt_make, evt_if.o_evt_code}), 32'h375);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("up_break_keys",  32'(o_keys),  32'h00);
    chk("up_break_count", 32'(o_count), 32'd2);
    idle(3, 1'b1);

    // space typematic suppressed, unmapped repeat kept
    send(8'h29); send(8'h29); send(8'h29); send(8'h1C); send(8'h1C);
    chk("repeat_count", 32'(o_count), 32'd3);
    chk("repeat_keys",  32'(o_keys),  32'h10);
    send(8'hF0); send(8'h29);
    idle(5, 1'b1);

    // overflow with six makes
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C); send(8'h35);
    chk("ovf_count", 32'(o_count),    32'd4);
    chk("ovf_flag",  32'(o_overflow), 32'd1);
    chk("ovf_head",  32'(evt_if.o_evt_code), 32'h15);
    idle(4, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clear", 32'(o_overflow), 32'd0);

    // full with simultaneous push and pop
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    send(8'h35, 1'b1);
    chk("full_pp_count", 32'(o_count),    32'd4);
    chk("full_pp_ovf",   32'(o_overflow), 32'd0);
    // clear and a new drop in the same cycle: set wins
    step(8'h2C, 1'b1, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(o_overflow), 32'd1);
    idle(5, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b1);

    // prefix timeout: exactly TMO idle cycles abandons the F0
    send(8'hF0); idle(TMO); send(8'h1C);
    chk("tmo_make", 32'(evt_if.o_evt_make), 32'd1);
    idle(2, 1'b1);
    // one cycle short keeps the prefix
    send(8'hF0); idle(TMO - 1); send(8'h1C);
    chk("tmo_short_make", 32'(evt_if.o_evt_make), 32'd0);
    idle(2, 1'b1);
    // reset discards the prefix
    send(8'hF0); step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1); send(8'h1C);
    chk("rst_prefix_make", 32'(evt_if.o_evt_make), 32'd1);
    idle(2, 1'b1);

    // ignored bytes
    send(8'hAA); send(8'hFA); send(8'hE0); send(8'hFE);
    chk("ignore_count", 32'(o_count), 32'd0);
    send(8'h75);
    chk("ignore_idle_ext", 32'(evt_if.o_evt_ext), 32'd0);
    idle(2, 1'b1);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      logic [7:0] b;
      b = pool[$urandom_range(0, 15)];
      if ($urandom_range(0, 5) == 0) b = 8'($urandom);
      if ($urandom_range(0, 60) == 0) idle($urandom_range(TMO - 2, TMO + 2), 1'($urandom));
      step(b, 1'($urandom_range(0, 2) != 0), 1'($urandom),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 250) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ps2_key_event.md
PS2_KEY_EVENT -- requirements
Module: ps2_key_event

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 4, event FIFO depth (power of two, 2..16).
REQ-002 SHALL provide parameter TIMEOUT_CYC, default 1000000, max idle cycles in a prefix state (20 ms at 50 MHz).
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have port i_byte  input  8  raw PS/2 scan-code byte from the PS/2 receiver.
REQ-006 SHALL have port i_byte_valid  input  1  one-cycle strobe; i_byte valid this cycle.
REQ-007 SHALL have port i_evt_ready  input  1  consumer accepts the head event this cycle.
REQ-008 SHALL have port o_evt_valid  output  1  FIFO not empty; head event presented.
REQ-009 SHALL have port o_evt_code  output  8  head event base scan code (prefixes stripped).
REQ-010 SHALL have port o_evt_ext  output  1  head event had the E0 prefix.
REQ-011 SHALL have port o_evt_make  output  1  1 = press, 0 = release.
REQ-012 SHALL have port o_keys  output  8  held bitmap: [0]up E0-75, [1]down E0-72, [2]left E0-6B, [3]right E0-74, [4]space 29, [5]enter 5A, [6]esc 76, [7]P 4D.
REQ-013 SHALL have port o_count  output  5  FIFO occupancy, 0..FIFO_DEPTH.
REQ-014 SHALL have port o_overflow  output  1  sticky: an event was dropped because the FIFO was full.
REQ-015 SHALL have port i_clr_ovf  input  1  one-cycle pulse that clears o_overflow.

Function
REQ-016 Prefix FSM SHALL have states IDLE, E0, F0, E0F0, updated only on cycles with i_byte_valid=1 (plus timeout, REQ-021).
REQ-017 Transitions: IDLE+E0->E0; IDLE+F0->F0; E0+F0->E0F0; E0+E0, F0+E0 and E0F0+E0 -> E0 (restart); F0+F0 and E0F0+F0 -> no change.
REQ-018 Any other byte SHALL complete an event {code=byte, ext=(state in E0,E0F0), make=(state in IDLE,E0)}, and the FSM SHALL return to IDLE.
REQ-019 Bytes 00, AA, E1, FA, FE, FF SHALL produce no event and return the FSM to IDLE from any state.
REQ-020 A completed event SHALL update o_keys on the same edge (set on make, clear on break, mapped keys only; ext must match the mapping).
REQ-021 In E0, F0 or E0F0, after TIMEOUT_CYC consecutive cycles without i_byte_valid, the FSM SHALL return to IDLE and discard the prefix; the counter SHALL reset on each i_byte_valid.
REQ-022 A make for a mapped key whose o_keys bit is already 1 (typematic repeat) SHALL NOT be enqueued; repeats of unmapped keys SHALL be enqueued.
REQ-023 Enqueue SHALL occur on the edge that samples the completing byte; o_evt_valid SHALL be high in the following cycle (latency 1).
REQ-024 Dequeue SHALL occur on an edge where o_evt_valid=1 and i_evt_ready=1; i_evt_ready while empty SHALL be ignored.
REQ-025 Head outputs SHALL remain stable while o_evt_valid=1 and i_evt_ready=0.
REQ-026 FIFO order SHALL be first-in first-out; pointers wrap modulo FIFO_DEPTH.
REQ-027 Push when full without a same-cycle pop: drop the event and set o_overflow; o_keys SHALL still update.
REQ-028 Push and pop in the same cycle when full: both SHALL be accepted, no drop, o_count unchanged.
REQ-029 Push and pop in the same cycle at any occupancy: o_count SHALL be unchanged.
REQ-030 i_clr_ovf together with a new overflow SHALL leave o_overflow=1 (set wins).

Reset
REQ-031 On i_rst=1 at a rising edge: FSM=IDLE, timeout counter=0, FIFO emptied, o_evt_valid=0, o_count=0, o_keys=0, o_overflow=0, o_evt_code/ext/make=0.
REQ-032 Reset SHALL override all inputs; a partial prefix sequence in progress SHALL be discarded, and a byte completing on the first cycle after reset SHALL be decoded from IDLE.

Verification
REQ-033 Bytes E0,75 with ready=0 -> one event {75,ext=1,make=1}, o_keys=0x01; then E0,F0,75 -> event {75,1,0}, o_keys=0x00, o_count=2.
REQ-034 Bytes 29,29,29 (space repeat), then 1C,1C -> events {29,0,1},{1C,0,1},{1C,0,1} only; o_keys[4]=1.
REQ-035 FIFO_DEPTH=4, ready=0, six make bytes 15,1D,24,2D,2C,35 -> o_count=4, o_overflow=1, pop order 15,1D,24,2D.
REQ-036 FIFO full with ready=1 and a completing byte in the same cycle -> o_count stays 4, no overflow, new event at the tail.
REQ-037 Byte F0, then TIMEOUT_CYC idle cycles, then 1C -> event {1C,0,make=1}; byte F0, then i_rst pulse, then 1C -> event {1C,0,1}.
REQ-038 Bytes AA, FA, E0 followed by FE -> no events, FSM=IDLE, o_count=0.
